// File: rtl/imem_loader_if.sv
// Byte-stream, instruction-memory write and status signals of the boot loader.
// The loader connects through the master modport, the byte source and memory through the slave modport.
interface imem_loader_if #(parameter int ADDR_W = 8);
  logic              start;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst_n;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  start, rx_valid, rx_data,
    output rx_ready, imem_we, imem_addr, imem_wdata, cpu_rst_n, busy, done, err
  );

  modport slave (
    output start, rx_valid, rx_data,
    input  rx_ready, imem_we, imem_addr, imem_wdata, cpu_rst_n, busy, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: fills instruction memory from a length-prefixed big-endian byte stream, holding the core in reset until done.
// Defining IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte that must match the data bytes.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input logic          clk,
  input logic          rst_n,
  imem_loader_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE
  } state_t;

  localparam logic [32:0] CAPACITY = 33'd1 << ADDR_W;

  state_t            state;
  logic [15:0]       len;
  logic [15:0]       len_next;
  logic [15:0]       wcnt;
  logic [23:0]       asm_r;
  logic [1:0]        bcnt;
  logic [ADDR_W-1:0] addr;
  logic              fin;
  logic              accept;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum;
  logic              bad;
`endif

  assign accept   = bus.rx_valid & bus.rx_ready;
  assign len_next = {len[15:8], bus.rx_data};

  // fin marks the cycle after the final accepted byte, so DONE and the core release land after the last write commits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      len            <= '0;
      wcnt           <= '0;
      asm_r          <= '0;
      bcnt           <= '0;
      addr           <= '0;
      fin            <= 1'b0;
      bus.rx_ready   <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      bus.cpu_rst_n  <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.err        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum           <= '0;
      bad            <= 1'b0;
`endif
    end else begin
      bus.imem_we <= 1'b0;
      if (fin) begin
        fin      <= 1'b0;
        state    <= S_DONE;
        bus.busy <= 1'b0;
        bus.done <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        bus.err       <= bad;
        bus.cpu_rst_n <= ~bad;
`else
        bus.cpu_rst_n <= 1'b1;
`endif
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (bus.start) begin
              state         <= S_LEN_HI;
              bus.done      <= 1'b0;
              bus.err       <= 1'b0;
              bus.cpu_rst_n <= 1'b0;
              bus.busy      <= 1'b1;
              bus.rx_ready  <= 1'b1;
              addr          <= '0;
              wcnt          <= '0;
              bcnt          <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
              csum          <= '0;
              bad           <= 1'b0;
`endif
            end
          end
          S_LEN_HI: begin
            if (accept) begin
              len[15:8] <= bus.rx_data;
              state     <= S_LEN_LO;
            end
          end
          S_LEN_LO: begin
            if (accept) begin
              len[7:0] <= bus.rx_data;
              if ({17'd0, len_next} > CAPACITY) begin
                state        <= S_IDLE;
                bus.err      <= 1'b1;
                bus.busy     <= 1'b0;
                bus.rx_ready <= 1'b0;
              end else if (len_next == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state         <= S_CHK;
`else
                state         <= S_DONE;
                bus.done      <= 1'b1;
                bus.cpu_rst_n <= 1'b1;
                bus.busy      <= 1'b0;
                bus.rx_ready  <= 1'b0;
`endif
              end else begin
                state <= S_DATA;
              end
            end
          end
          S_DATA: begin
            if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              csum <= csum ^ bus.rx_data;
`endif
              bcnt <= bcnt + 2'd1;
              if (bcnt == 2'd3) begin
                bus.imem_we    <= 1'b1;
                bus.imem_wdata <= {asm_r, bus.rx_data};
                bus.imem_addr  <= addr;
                addr           <= addr + 1'b1;
                wcnt           <= wcnt + 16'd1;
                if (wcnt == len - 16'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  state        <= S_CHK;
`else
                  fin          <= 1'b1;
                  bus.rx_ready <= 1'b0;
`endif
                end
              end else begin
                asm_r <= {asm_r[15:0], bus.rx_data};
              end
            end
          end
`ifdef IMEM_LOADER_CHECKSUM_EN
          S_CHK: begin
            if (accept) begin
              bad          <= (bus.rx_data != csum);
              fin          <= 1'b1;
              bus.rx_ready <= 1'b0;
            end
          end
`endif
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of whole-load vectors plus reset sequences, writes checked by a scoreboard.
// Checksum vectors are included when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

  localparam int ADDR_W = 2;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  typedef struct {
    logic [15:0]      len;
    int               gap;
    logic [3:0][31:0] words;
    bit               bad_chk;
    bit               exp_done;
    bit               exp_err;
    bit               exp_cpu;
  } vec_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passed = 0;
  wr_t  exp_q[$];
  vec_t vec_q[$];
  logic prev_we = 1'b0;

  imem_loader_if #(.ADDR_W(ADDR_W)) ifc ();

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc.master)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard: every write pulse must match the oldest pending expected write and last exactly one cycle
  always @(negedge clk) begin
    if (ifc.imem_we === 1'b1) begin
      checkOutput("we_single_cycle", 32'(prev_we), 32'd0);
      checkOutput("write_was_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        wr_t e;
        e = exp_q.pop_front();
        checkOutput("write_addr", 32'(ifc.imem_addr), 32'(e.addr));
        checkOutput("write_data", ifc.imem_wdata, e.data);
      end
    end
    prev_we <= (ifc.imem_we === 1'b1);
  end

  function automatic vec_t mk(input logic [15:0] len, input int gap,
                              input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3,
                              input bit bad, input bit d, input bit e, input bit c);
    vec_t v;
    v.len = len; v.gap = gap;
    v.words[0] = w0; v.words[1] = w1; v.words[2] = w2; v.words[3] = w3;
    v.bad_chk = bad; v.exp_done = d; v.exp_err = e; v.exp_cpu = c;
    return v;
  endfunction

  task automatic sendByte(input logic [7:0] b, input int gap);
    int budget = 50;
    repeat (gap) begin @(posedge clk); #1; end
    ifc.rx_valid = 1'b1;
    ifc.rx_data  = b;
    @(negedge clk);
    while (ifc.rx_ready !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (ifc.rx_ready !== 1'b1) checkOutput("rx_ready_timeout", 32'(ifc.rx_ready), 32'd1);
    @(posedge clk);
    #1;
    ifc.rx_valid = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_rx_ready"}, 32'(ifc.rx_ready), 32'd0);
    checkOutput({tag, "_imem_we"}, 32'(ifc.imem_we), 32'd0);
    checkOutput({tag, "_imem_addr"}, 32'(ifc.imem_addr), 32'd0);
    checkOutput({tag, "_imem_wdata"}, ifc.imem_wdata, 32'd0);
    checkOutput({tag, "_cpu_rst_n"}, 32'(ifc.cpu_rst_n), 32'd0);
    checkOutput({tag, "_busy"}, 32'(ifc.busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(ifc.done), 32'd0);
    checkOutput({tag, "_err"}, 32'(ifc.err), 32'd0);
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [7:0]  x;
    logic [7:0]  bt;
    logic [31:0] wd;
    bit          ovf;
    bit          immediate;
    x   = 8'h00;
    ovf = (int'(v.len) > (1 << ADDR_W));
    immediate = ovf || (v.len == 16'd0 && !CHK_EN);
    ifc.start = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    checkOutput("busy_after_start", 32'(ifc.busy), 32'd1);
    checkOutput("cpu_held_in_reset", 32'(ifc.cpu_rst_n), 32'd0);
    sendByte(v.len[15:8], 0);
    sendByte(v.len[7:0], v.gap);
    if (!ovf) begin
      for (int w = 0; w < int'(v.len); w++) begin
        wd = v.words[w];
        for (int k = 0; k < 4; k++) begin
          bt = wd[31-8*k -: 8];
          x  = x ^ bt;
          if (k == 3) exp_q.push_back('{addr: ADDR_W'(w), data: wd});
          sendByte(bt, v.gap);
        end
      end
      if (CHK_EN) sendByte(x ^ {7'd0, v.bad_chk}, v.gap);
    end
    if (!immediate) begin
      checkOutput("done_not_early", 32'(ifc.done), 32'd0);
      checkOutput("cpu_not_early", 32'(ifc.cpu_rst_n), 32'd0);
      @(posedge clk); #1;
    end
    checkOutput("final_done", 32'(ifc.done), 32'(v.exp_done));
    checkOutput("final_err", 32'(ifc.err), 32'(v.exp_err));
    checkOutput("final_cpu_rst_n", 32'(ifc.cpu_rst_n), 32'(v.exp_cpu));
    checkOutput("final_busy", 32'(ifc.busy), 32'd0);
    checkOutput("final_rx_ready", 32'(ifc.rx_ready), 32'd0);
    checkOutput("writes_outstanding", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_q.push_back(mk(16'd2, 0, 32'h20080005, 32'hAC080004, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1));
    vec_q.push_back(mk(16'd2, 3, 32'h20080005, 32'hAC080004, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1));
    vec_q.push_back(mk(16'd5, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0));
    vec_q.push_back(mk(16'd0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1));
    vec_q.push_back(mk(16'd4, 1, 32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00, 1'b0, 1'b1, 1'b0, 1'b1));
    vec_q.push_back(mk(16'd1, 0, 32'h12345678, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1));
`ifdef IMEM_LOADER_CHECKSUM_EN
    vec_q.push_back(mk(16'd1, 0, 32'h12345678, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0));
`endif

    ifc.start    = 1'b0;
    ifc.rx_valid = 1'b0;
    ifc.rx_data  = 8'h00;

    // Power-on reset, then idle with no start
    repeat (3) @(negedge clk);
    checkResetValues("por");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checkResetValues("idle");
    @(posedge clk); #1;

    // Reset mid-load after six bytes: one word written, second word abandoned
    ifc.start = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    sendByte(8'h00, 0);
    sendByte(8'h02, 0);
    sendByte(8'h20, 0);
    sendByte(8'h08, 0);
    sendByte(8'h00, 0);
    exp_q.push_back('{addr: ADDR_W'(0), data: 32'h20080005});
    sendByte(8'h05, 0);
    sendByte(8'hAC, 0);
    sendByte(8'h08, 0);
    @(negedge clk); #1;
    checkOutput("midload_busy", 32'(ifc.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkResetValues("midload_reset");
    checkOutput("midload_writes_outstanding", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < vec_q.size(); i++) applyStimulus(vec_q[i]);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that writes the processor's instruction memory from a byte stream, such as a UART receiver or a testbench feeder. It holds the core in reset while loading and releases it when the image is in place. It owns the write side of the instruction memory; the core only reads that memory through its PC. It sits beside the MIPS top, between the byte source and the instruction memory write port.

## Interface

**Parameters**
- `ADDR_W`, default 8: instruction-memory word-address width. Capacity is 2^ADDR_W words.

**Ports**
- `clk` input, 1: rising-edge clock.
- `rst_n` input, 1: asynchronous, active-low reset.
- `start` input, 1: one-cycle request to begin a load.
- `rx_valid` input, 1: `rx_data` holds a byte.
- `rx_data` input, 8: stream byte.
- `rx_ready` output, 1: loader accepts a byte this cycle.
- `imem_we` output, 1: instruction-memory write enable.
- `imem_addr` output, ADDR_W: word address of the write.
- `imem_wdata` output, 32: word to write.
- `cpu_rst_n` output, 1: active-low reset to the core; low while the image is invalid.
- `busy` output, 1: load in progress.
- `done` output, 1: last load completed.
- `err` output, 1: last load failed.

## Operation

- **Stream format**
  - LEN_HI, LEN_LO: 16-bit word count N, big-endian.
  - Then N×4 data bytes, each word big-endian (first byte goes to bits 31:24).
  - Then a checksum byte, only when the macro is defined.
- **States:** IDLE, LEN_HI, LEN_LO, DATA, CHK (macro only), DONE.
- **IDLE / DONE**
  - `start` moves to LEN_HI.
  - On that move: clear `done` and `err`, drive `cpu_rst_n` to 0, zero the address and byte counters, clear the checksum accumulator.
- **LEN_HI → LEN_LO → DATA** on each accepted byte.
- **After LEN_LO is accepted:**
  - N = 0: go to DONE. With the macro defined, go to CHK instead.
  - N > 2^ADDR_W: go to IDLE with `err`=1, `done`=0, `cpu_rst_n` kept at 0. No memory writes occur.
- **DATA**
  - Bytes shift into a 32-bit assembly register.
  - On the 4th byte of a word, the assembled word and current address are registered into `imem_wdata`/`imem_addr`, and `imem_we` is set for one cycle.
  - The address then increments.
  - After word N: go to DONE, or CHK with the macro defined.
- **DONE:** `done`=1, `cpu_rst_n`=1, `busy`=0.
- **`start` in LEN_HI / LEN_LO / DATA / CHK:** ignored.
- **`busy`:** 1 in LEN_HI, LEN_LO, DATA and CHK.
- **Address arithmetic:** the address counter is ADDR_W wide. N = 2^ADDR_W fills memory exactly; the counter wraps to 0 after the last write, but no further write occurs.

## Timing

- **Reset values:**
  - State IDLE.
  - `rx_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0.
  - `cpu_rst_n`=0, `busy`=0, `done`=0, `err`=0.
- **Byte transfer:** a byte is transferred on a rising edge where `rx_valid` & `rx_ready`.
- **`rx_ready`:** a registered function of state; 1 in LEN_HI, LEN_LO, DATA and CHK. It never stalls during a write, so back-to-back bytes are sustained at one per cycle.
- **Write latency:**
  - 4th byte accepted at edge k.
  - `imem_we`=1 for exactly the cycle between edge k and edge k+1.
  - The write commits at edge k+1.
- **Completion:** if edge k accepted the last data byte and there is no checksum, the state becomes DONE at edge k+1. `done` and `cpu_rst_n` rise at edge k+1, so the core leaves reset only after the final write has committed.
- **Reset mid-load:**
  - Aborts immediately and everything returns to reset values.
  - Partially written memory is left as is.
  - `cpu_rst_n` stays 0 until a complete load finishes.
- **`rx_valid` low mid-word:** assembly pauses; the partial word and byte count are held indefinitely.

## Configuration

- **`IMEM_LOADER_CHECKSUM_EN` defined:**
  - After the last data byte (or directly after LEN_LO when N = 0), the state enters CHK and accepts one byte.
  - Byte equals the XOR of all data bytes: go to DONE.
  - Mismatch: go to DONE with `err`=1, `done`=1, `cpu_rst_n` kept at 0.
  - Completion moves one edge later, to the edge after the checksum byte is accepted.
- **Undefined:**
  - No CHK state and no trailing byte.
  - `err` is raised only by length overflow.

## Test plan

- **Reset:** `rst_n` low, then high with no `start` → `cpu_rst_n`=0, `rx_ready`=0, `done`=0, and no `imem_we` ever asserts.
- **Two-word load, continuous:** `start`, then bytes 00 02 20 08 00 05 AC 08 00 04 → writes (0, 0x20080005) and (1, 0xAC080004). Each `imem_we` pulse is one cycle. `done` and `cpu_rst_n` rise one edge after the last byte.
- **Gapped valid:** same stream with `rx_valid` dropped for 3 cycles after each byte → identical writes and addresses; no extra or missing `imem_we`.
- **Overflow and zero length:**
  - With ADDR_W=2: length 00 05 → `err`=1, `done`=0, no writes, state IDLE.
  - With ADDR_W=2: length 00 00 → `done`=1 with no writes.
- **Reset mid-load:** assert `rst_n` low after 6 bytes → all outputs return to reset values. A following full load then succeeds.
- **Checksum (macro defined), one-word image 12 34 56 78:**
  - Trailer 08 → `done`=1, `cpu_rst_n`=1.
  - Trailer 09 → `err`=1, `cpu_rst_n`=0.
